// File: rtl/mac_engine_vec.sv
// Multi-lane signed MAC engine: streaming element-wise multiply or length-counted scalar
// product with c preload, followed by per-lane rounding, shifting and saturating narrowing.
module mac_engine_vec #(
  parameter int unsigned NB_LANES = 4,
  parameter int unsigned DW       = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ACC_W    = 2*DW+CNT_W,
  localparam int unsigned SW      = $clog2(2*DW),
  localparam int unsigned BW      = NB_LANES*DW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_mode_i,
  input  logic [BW-1:0]    a_data_i,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [BW-1:0]    b_data_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [BW-1:0]    c_data_i,
  input  logic             c_valid_i,
  output logic             c_ready_o,
  output logic [BW-1:0]    d_data_o,
  output logic [BW/8-1:0]  d_strb_o,
  output logic             d_valid_o,
  input  logic             d_ready_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic             simple_mul_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [SW-1:0]    shift_i,
  input  logic             round_en_i,
  input  logic             sat_en_i,
  output logic             busy_o,
  output logic             acc_done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam int unsigned PW = 2*DW;

  typedef enum logic [1:0] {StIdle, StLoadC, StAccum, StOut} state_e;

  state_e                   state_q;
  logic signed [PW-1:0]     mult_q [NB_LANES];
  logic                     mult_valid_q;
  logic signed [ACC_W-1:0]  acc_q  [NB_LANES];
  logic [CNT_W-1:0]         cnt_q, issued_q;
  logic                     sat_q;

  logic signed [PW-1:0]     prod    [NB_LANES];
  logic signed [ACC_W-1:0]  post_in [NB_LANES];
  logic signed [ACC_W-1:0]  shd     [NB_LANES];
  logic [ACC_W-DW:0]        hi      [NB_LANES];
  logic signed [ACC_W-1:0]  rnd;
  logic [NB_LANES-1:0]      clamp;
  logic                     ab_hs, c_hs, d_hs;
  logic                     unused_test_mode;

  assign unused_test_mode = test_mode_i;
  assign d_strb_o         = '1;
  assign busy_o           = (state_q != StIdle);
  assign cnt_o            = cnt_q;
  assign sat_o            = sat_q;
  assign b_ready_o        = a_ready_o;

  // Handshake control; readies are withheld during clear so no beat is silently dropped.
  always_comb begin
    a_ready_o = 1'b0;
    c_ready_o = 1'b0;
    d_valid_o = 1'b0;
    if (enable_i) begin
      if (simple_mul_i) begin
        a_ready_o = a_valid_i & b_valid_i & (~mult_valid_q | d_ready_i) & ~clear_i;
        d_valid_o = mult_valid_q;
      end else begin
        a_ready_o = a_valid_i & b_valid_i & (state_q == StAccum) & (issued_q < len_i) & ~clear_i;
        c_ready_o = (state_q == StLoadC) & ~clear_i;
        d_valid_o = (state_q == StOut);
      end
    end
  end

  assign ab_hs      = a_valid_i & b_valid_i & a_ready_o;
  assign c_hs       = c_valid_i & c_ready_o;
  assign d_hs       = d_valid_o & d_ready_i;
  assign acc_done_o = d_hs & ~simple_mul_i;

  always_comb begin
    for (int l = 0; l < NB_LANES; l++) begin
      prod[l] = PW'($signed(a_data_i[l*DW +: DW])) * PW'($signed(b_data_i[l*DW +: DW]));
    end
  end

  // Output post-processing: optional round half-up, arithmetic shift, optional clamp.
  always_comb begin
    rnd      = '0;
    clamp    = '0;
    d_data_o = '0;
    if (round_en_i && (shift_i != '0)) rnd[shift_i - SW'(1)] = 1'b1;
    for (int l = 0; l < NB_LANES; l++) begin
      post_in[l] = simple_mul_i ? ACC_W'(mult_q[l]) : acc_q[l];
      shd[l]     = (post_in[l] + rnd) >>> shift_i;
      hi[l]      = shd[l][ACC_W-1:DW-1];
      d_data_o[l*DW +: DW] = shd[l][DW-1:0];
      if (sat_en_i && !((&hi[l]) || !(|hi[l]))) begin
        clamp[l] = 1'b1;
        d_data_o[l*DW +: DW] = shd[l][ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      mult_valid_q <= 1'b0;
      cnt_q        <= '0;
      issued_q     <= '0;
      sat_q        <= 1'b0;
      for (int l = 0; l < NB_LANES; l++) begin
        mult_q[l] <= '0;
        acc_q[l]  <= '0;
      end
    end else if (clear_i) begin
      state_q      <= StIdle;
      mult_valid_q <= 1'b0;
      cnt_q        <= '0;
      issued_q     <= '0;
      sat_q        <= 1'b0;
      for (int l = 0; l < NB_LANES; l++) begin
        mult_q[l] <= '0;
        acc_q[l]  <= '0;
      end
    end else if (enable_i) begin
      if (ab_hs) begin
        for (int l = 0; l < NB_LANES; l++) mult_q[l] <= prod[l];
      end
      // In scalar mode every product is consumed the cycle after it is registered.
      if (simple_mul_i) mult_valid_q <= ab_hs | (mult_valid_q & ~d_ready_i);
      else              mult_valid_q <= ab_hs;

      if (d_hs && (|clamp)) sat_q <= 1'b1;

      if (!simple_mul_i) begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q  <= StLoadC;
              cnt_q    <= '0;
              issued_q <= '0;
            end
          end
          StLoadC: begin
            if (c_hs) begin
              for (int l = 0; l < NB_LANES; l++) begin
                acc_q[l] <= ACC_W'($signed(c_data_i[l*DW +: DW])) <<< shift_i;
              end
              state_q <= (len_i == '0) ? StOut : StAccum;
            end
          end
          StAccum: begin
            if (ab_hs) issued_q <= issued_q + CNT_W'(1);
            if (mult_valid_q) begin
              for (int l = 0; l < NB_LANES; l++) acc_q[l] <= acc_q[l] + ACC_W'(mult_q[l]);
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q + CNT_W'(1) == len_i) state_q <= StOut;
            end
          end
          StOut: begin
            if (d_hs) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/mac_engine_vec.md
# mac_engine_vec

Parametrised, multi-lane successor of the single-lane 32b MAC engine in the HWPE datapath. It has NB_LANES independent signed DW-bit multiply/accumulate lanes that share one set of HWPE-Stream handshakes. Two modes are supported: streaming element-wise multiply, and length-counted scalar product with a c_i preload. The output stage adds round-to-nearest and saturating narrowing. It sits between the streamer sources/sink and the control slave, like its predecessor.

## Interface
- NB_LANES, 4, number of parallel lanes packed in every stream beat (lane l = bits [l*DW +: DW])
- DW, 16, signed operand/output width per lane
- CNT_W, 16, width of len and counters
- ACC_W, 2*DW+CNT_W, per-lane accumulator width (two's complement)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- test_mode_i  in  1  unused, reserved
- a_i, b_i  hwpe_stream sink  NB_LANES*DW  multiplicand streams
- c_i  hwpe_stream sink  NB_LANES*DW  accumulator preload stream (scalar-product mode only)
- d_o  hwpe_stream source  NB_LANES*DW  result stream; strb all ones
- clear_i  in  1  synchronous clear to reset state
- enable_i  in  1  global enable; low freezes all state
- start_i  in  1  one-cycle job start (scalar-product mode)
- simple_mul_i  in  1  1 = element-wise multiply, 0 = scalar product
- len_i  in  CNT_W  products per scalar-product job
- shift_i  in  $clog2(2*DW)  fixed-point shift amount
- round_en_i, sat_en_i  in  1  output rounding / saturation enables
- busy_o  out  1  FSM not IDLE
- acc_done_o  out  1  one-cycle pulse on the d_o handshake that ends a job
- cnt_o  out  CNT_W  products accumulated in the current job
- sat_o  out  1  sticky: any lane saturated since the last clear

## Operation
- All outputs reset to 0: d_o.valid, d_o.data, all readies, busy_o, acc_done_o, cnt_o, sat_o. The FSM resets to IDLE. clear_i has the same effect synchronously and has priority over enable_i.
- enable_i=0: no register updates; all readies and d_o.valid are forced to 0.
- Control inputs must be stable from start_i until acc_done_o. A mode change mid-job is undefined.
- Lane product: signed DW×DW -> 2*DW, registered in r_mult[l] together with one shared r_mult_valid.
- Post-processing, per lane on value v with s=shift_i:
  - If round_en_i and s>0, add 2^(s-1).
  - Arithmetic shift right by s.
  - If sat_en_i, clamp to [-2^(DW-1), 2^(DW-1)-1] and set sat_o when clamping occurs; otherwise keep the low DW bits.
- Simple-multiply mode (FSM ignored, stays IDLE):
  - a_i.ready = b_i.ready = a_i.valid & b_i.valid & (~r_mult_valid | d_o.ready).
  - d_o.valid = r_mult_valid. d_o.data = post(r_mult).
- Scalar-product FSM:
  - IDLE: start_i goes to LOAD_C. cnt and issue counter := 0.
  - LOAD_C: c_i.ready=1. On the handshake, acc[l] := sext(c[l]) <<< s. Then go to ACCUM, or to OUT if len_i=0.
  - ACCUM: a/b ready = both valid & issued<len_i. On each a/b handshake, issued++. Every valid r_mult is added to acc in the same cycle (always consumed). cnt++ on each add. When an add makes cnt==len_i, go to OUT.
  - OUT: d_o.valid=1, d_o.data=post(acc). On the d_o handshake: acc_done_o=1, return to IDLE.
- c_i.ready is 0 outside LOAD_C. a/b readies are 0 outside ACCUM in this mode.
- The accumulator wraps modulo 2^ACC_W; there is no internal saturation.
- start_i outside IDLE is ignored.

## Timing
- Simple mode: a/b handshake at cycle t -> d_o.valid at t+1. Throughput is 1 beat/cycle when d_o.ready=1. d_o.data stays stable while valid & ~ready.
- Scalar mode:
  - start at t -> LOAD_C at t+1.
  - c handshake at t -> ACCUM at t+1.
  - Last a/b handshake at t -> acc final at t+2, d_o.valid at t+2.
  - Minimum job is len+4 cycles.
- d_o.valid never deasserts without a handshake. In simple mode, r_mult is never overwritten while valid & ~ready.
- Backpressure on d_o in OUT holds acc and the FSM. An a/b stall in ACCUM inserts bubbles only.

## Test plan
- Reset/clear: assert clear_i mid-ACCUM with len=8 after 3 products -> next cycle busy_o=0, cnt_o=0, d_o.valid=0, readies 0.
- Simple mode, DW=16, shift=0:
  - a=3, b=-5 on all lanes, d_o.ready=1 -> d=-15 per lane one cycle later.
  - 10 back-to-back beats -> 10 results.
  - Random d_o.ready toggling -> no loss or duplication.
- Scalar product, len=4, c=2, shift=0, a=b={1,2,3,4} sequential -> single d beat = 32 per lane, acc_done_o pulses once, cnt_o=4.
- len=0, c=7, shift=3 -> d=7 with no a/b ready asserted, transition LOAD_C->OUT.
- Round/saturate, simple mode, shift=4:
  - a=100, b=100 (10000): round_en=1, sat_en=1 -> 625.
  - a=b=32767, shift=0, sat_en=1 -> 32767 and sat_o=1.
  - Same with sat_en=0 -> low 16 bits = 1, sat_o unchanged.
- Backpressure: hold d_o.ready=0 for 5 cycles in OUT -> d_o.data stable, a/b/c readies 0, completes on ready.
